// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types and sizes for the round-robin arbiters
package arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic {
    IDLE,
    HOLD
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin winner search
// Scans req & ~mask in the order ptr, ptr+1, ... (mod NUM_REQ).
module rr_pick
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  input  logic [NUM_REQ-1:0] mask,
  output logic [SEL_W-1:0]   winner,
  output logic               found
);

  logic [NUM_REQ-1:0] elig;
  logic [SEL_W-1:0]   idx;

  always_comb begin
    elig   = req & ~mask;
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    // Walk from the farthest candidate back to ptr so the nearest one wins.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = ptr + SEL_W'(k);
      if (elig[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_mux_arbiter.sv
// rtl/rr_mux_arbiter.sv - 4-way round-robin arbiter driving a MUX4_1 select
// Grant is held until DONE, withdrawal of the owner's request, or watchdog expiry.
module rr_mux_arbiter
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [NUM_REQ-1:0] REQ,
  input  logic               DONE,
  output logic [NUM_REQ-1:0] GNT,
  output logic [SEL_W-1:0]   SEL,
  output logic               VALID,
  output logic               TIMEOUT
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  arb_state_t         state_q, state_n;
  logic [SEL_W-1:0]   ptr_q, ptr_n;
  logic [CNT_W-1:0]   cnt_q, cnt_n;
  logic [NUM_REQ-1:0] gnt_n;
  logic [SEL_W-1:0]   sel_n;
  logic               valid_n;
  logic               timeout_n;

  logic [SEL_W-1:0]   win;
  logic               found;
  logic               expire;
  logic               rel;
  logic               take_new;

  // GNT is zero in IDLE, so it doubles as the "exclude the releasing owner" mask.
  rr_pick u_pick (
    .req    (REQ),
    .ptr    (ptr_q),
    .mask   (GNT),
    .winner (win),
    .found  (found)
  );

  always_comb begin
    state_n   = state_q;
    ptr_n     = ptr_q;
    cnt_n     = cnt_q;
    gnt_n     = GNT;
    sel_n     = SEL;
    valid_n   = VALID;
    timeout_n = 1'b0;
    take_new  = 1'b0;
    expire    = (MAX_HOLD != 0) && (cnt_q == HOLD_LAST) && !DONE;
    rel       = DONE || !REQ[SEL] || expire;

    case (state_q)
      IDLE: begin
        if (found) take_new = 1'b1;
      end
      HOLD: begin
        if (rel) begin
          timeout_n = expire;
          if (found) begin
            take_new = 1'b1;
          end else begin
            state_n = IDLE;
            gnt_n   = '0;
            valid_n = 1'b0;
          end
        end else if (cnt_q != '1) begin
          cnt_n = cnt_q + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    if (take_new) begin
      state_n    = HOLD;
      gnt_n      = '0;
      gnt_n[win] = 1'b1;
      sel_n      = win;
      valid_n    = 1'b1;
      ptr_n      = win + 1'b1;
      cnt_n      = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      GNT     <= '0;
      SEL     <= '0;
      VALID   <= 1'b0;
      TIMEOUT <= 1'b0;
    end else begin
      state_q <= state_n;
      ptr_q   <= ptr_n;
      cnt_q   <= cnt_n;
      GNT     <= gnt_n;
      SEL     <= sel_n;
      VALID   <= valid_n;
      TIMEOUT <= timeout_n;
    end
  end

endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
- Round-robin arbiter that shares one resource (e.g. a memory or bus port) between four requesters.
- Drives the 2-bit SEL of the team's 4:1 datapath multiplexer (MUX4_1) that steers the granted requester's address/data onto the resource.
- Holds the grant until the resource signals completion, the requester withdraws, or a watchdog expires.
- Sits between the pipeline stages that share the port and the MUX4_1 instance.

Parameters:
- MAX_HOLD, 16: maximum cycles one grant may be held; 0 disables the watchdog.
- CNT_W, 8: hold-counter width; MAX_HOLD must be below 2^CNT_W.

Ports:
- CLK  input  1  clock, all state updates on rising edge
- RST  input  1  synchronous, active-high reset
- REQ  input  4  request per requester; bit i = requester i
- DONE  input  1  resource finished current transaction (single-cycle pulse)
- GNT  output  4  one-hot grant, registered
- SEL  output  2  binary index of current/last grant, to MUX4_1 SEL
- VALID  output  1  a grant is active (GNT != 0)
- TIMEOUT  output  1  one-cycle pulse when the watchdog forces release

Behaviour:
- Reset (RST=1 at a rising edge): GNT=0, SEL=0, VALID=0, TIMEOUT=0, state=IDLE, priority pointer=0, hold counter=0. Reset mid-grant drops GNT on the next edge; no DONE is required.
- States: IDLE (no grant) and HOLD (exactly one GNT bit set).
- Priority pointer P (2 bits): search order P, P+1, P+2, P+3, modulo 4.
- After a grant to i, P becomes i+1 mod 4, so 3 wraps to 0.
- IDLE, REQ != 0: pick the winner w by the search order. Next cycle: state=HOLD, GNT=1<<w, SEL=w, VALID=1, counter=0. Latency from REQ sampled to GNT is 1 cycle.
- IDLE, REQ == 0: remain IDLE, outputs unchanged. SEL keeps its last value so the mux does not toggle.
- HOLD, release condition: DONE=1, or REQ[SEL]=0 (withdrawal), or watchdog expiry.
- Watchdog expiry: MAX_HOLD!=0 and counter==MAX_HOLD-1 with no DONE.
- HOLD, no release: counter increments; GNT and SEL are stable.
- On release with other requests pending (REQ with bit SEL masked off is nonzero): back-to-back grant next cycle to the winner from the updated P. No idle bubble.
- On release with none pending: go to IDLE next cycle, GNT=0, VALID=0.
- The releasing requester is never re-granted in the same cycle, even if its REQ stays high. It may win later per round-robin.
- Simultaneous DONE and expiry: treated as DONE; TIMEOUT stays 0.
- TIMEOUT=1 only in the cycle after a forced release.
- DONE while IDLE: ignored.
- Counter saturates; it never wraps.
- Fairness: with all four REQ held high and DONE every cycle, grants follow 0,1,2,3,0,… and each requester waits at most 3 grants.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Decomposition:
- Shared package arb_pkg:
  - typedef enum {IDLE, HOLD} arb_state_t
  - localparam NUM_REQ=4
  - localparam SEL_W=2
- One natural sub-module: rr_pick. It is combinational and takes REQ, the pointer and a mask, and returns the winner index plus a found flag. It is reusable by later arbiters.
- MUX4_1 is instantiated by the parent, not inside this block.

Test Plan:
- Reset then REQ=4'b0100 -> next cycle GNT=4'b0100, SEL=2, VALID=1; DONE pulse -> next cycle GNT=0, VALID=0, SEL stays 2.
- After a grant to 2, REQ=4'b1111 with DONE every cycle -> grant order 3,0,1,2,3; no idle cycles between grants.
- MAX_HOLD=4, REQ=4'b0001, no DONE -> GNT[0] held 4 cycles, then released. TIMEOUT=1 for exactly one cycle and GNT=0. A re-grant to 0 follows the next cycle if REQ[0] is still high.
- In HOLD on requester 1, drop REQ[1] while REQ[3]=1 -> next cycle GNT=4'b1000, SEL=3, TIMEOUT=0.
- DONE coincident with the watchdog's final count -> normal release, TIMEOUT=0.
- RST asserted during HOLD on requester 2 -> next edge GNT=0, SEL=0, VALID=0, pointer=0. A subsequent REQ=4'b1111 is granted to 0 first.
